// File: rtl/mem_fairness_pkg.sv
// Shared constants and helpers for the memory-bus fairness monitor.
package mem_fairness_pkg;

    // Violation classes; lower value wins when several fire together.
    localparam logic [1:0] VIOL_STALL = 2'd0;
    localparam logic [1:0] VIOL_HOLD  = 2'd1;
    localparam logic [1:0] VIOL_ERR   = 2'd2;
    localparam logic [1:0] VIOL_SLEEP = 2'd3;

    // Error-response policies.
    localparam int unsigned ERR_MODE_NONE = 0;
    localparam int unsigned ERR_MODE_PHYS = 1;

    // first_viol layout: [7:6] class, [5:0] channel index.
    function automatic logic [7:0] pack_first_viol(input logic [1:0] cls, input logic [5:0] ch);
        return {cls, ch};
    endfunction

endpackage

// File: rtl/mem_chan_fairness.sv
// Per-channel fairness checks: stall bound, request hold stability, error policy.
module mem_chan_fairness
    import mem_fairness_pkg::*;
#(
    parameter int unsigned MEM_ADDR_W  = 64,
    parameter int unsigned MEM_DATA_W  = 64,
    parameter int unsigned MEM_STRB_W  = 8,
    parameter int unsigned PHYS_ADDR_W = 32,
    parameter int unsigned ERR_MODE    = 1,
    parameter int unsigned MAX_STALL   = 5,
    parameter int unsigned CTR_W       = 5
) (
    input  logic                  g_clk,
    input  logic                  g_resetn,
    input  logic                  req,
    input  logic                  gnt,
    input  logic                  err,
    input  logic [MEM_ADDR_W-1:0] addr,
    input  logic                  wen,
    input  logic [MEM_STRB_W-1:0] strb,
    input  logic [MEM_DATA_W-1:0] wdata,
    output logic [CTR_W-1:0]      stall_ctr,
    output logic                  rsp_pending,
    output logic                  viol_stall,
    output logic                  viol_hold,
    output logic                  viol_err,
    output logic                  viol_stall_c,
    output logic                  viol_hold_c,
    output logic                  viol_err_c
);

    logic                  stalled_c;
    logic                  oor_c;
    logic                  stall_fired;
    logic                  waiting;
    logic                  rsp_oor;
    logic [MEM_ADDR_W-1:0] snap_addr;
    logic                  snap_wen;
    logic [MEM_STRB_W-1:0] snap_strb;
    logic [MEM_DATA_W-1:0] snap_wdata;

    assign stalled_c = req & ~gnt;
    // Any address bit at or above the physical width marks the access out of range.
    assign oor_c     = (addr >> PHYS_ADDR_W) != '0;

    // Violation conditions evaluated in the offending cycle.
    always_comb begin
        viol_stall_c = stalled_c && (stall_ctr == CTR_W'(MAX_STALL)) && !stall_fired;
        viol_hold_c  = waiting && (!req || (addr != snap_addr) || (wen != snap_wen) ||
                       (snap_wen && ((strb != snap_strb) || (wdata != snap_wdata))));
        if (ERR_MODE == ERR_MODE_NONE) begin
            viol_err_c = rsp_pending && err;
        end else begin
            viol_err_c = rsp_pending && (err != rsp_oor);
        end
    end

    // Saturating stall counter with a once-per-episode report flag.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            stall_ctr   <= '0;
            stall_fired <= 1'b0;
            viol_stall  <= 1'b0;
        end else begin
            viol_stall <= viol_stall_c;
            if (stalled_c) begin
                if (stall_ctr != '1) begin
                    stall_ctr <= stall_ctr + CTR_W'(1);
                end
                stall_fired <= stall_fired | viol_stall_c;
            end else begin
                stall_ctr   <= '0;
                stall_fired <= 1'b0;
            end
        end
    end

    // Snapshot of a stalled request and the next-cycle stability check.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            waiting    <= 1'b0;
            snap_addr  <= '0;
            snap_wen   <= 1'b0;
            snap_strb  <= '0;
            snap_wdata <= '0;
            viol_hold  <= 1'b0;
        end else begin
            viol_hold <= viol_hold_c;
            waiting   <= stalled_c && !viol_hold_c;
            if (stalled_c) begin
                snap_addr  <= addr;
                snap_wen   <= wen;
                snap_strb  <= strb;
                snap_wdata <= wdata;
            end
        end
    end

    // Response tracking for the error-policy check one cycle after a grant.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            rsp_pending <= 1'b0;
            rsp_oor     <= 1'b0;
            viol_err    <= 1'b0;
        end else begin
            viol_err    <= viol_err_c;
            rsp_pending <= req & gnt;
            if (req && gnt) begin
                rsp_oor <= oor_c;
            end
        end
    end

endmodule

// File: rtl/mem_bus_fairness_monitor.sv
// Fairness monitor for NCH request/grant memory channels plus WFI sleep bound.
module mem_bus_fairness_monitor
    import mem_fairness_pkg::*;
#(
    parameter int unsigned NCH         = 2,
    parameter int unsigned MEM_ADDR_W  = 64,
    parameter int unsigned MEM_DATA_W  = 64,
    parameter int unsigned MEM_STRB_W  = 8,
    parameter int unsigned PHYS_ADDR_W = 32,
    parameter int unsigned ERR_MODE    = 1,
    parameter int unsigned MAX_STALL   = 5,
    parameter int unsigned MAX_SLEEP   = 10,
    parameter int unsigned CTR_W       = 5
) (
    input  logic                      g_clk,
    input  logic                      g_resetn,
    input  logic [NCH-1:0]            ch_req,
    input  logic [NCH-1:0]            ch_gnt,
    input  logic [NCH-1:0]            ch_err,
    input  logic [NCH*MEM_ADDR_W-1:0] ch_addr,
    input  logic [NCH-1:0]            ch_wen,
    input  logic [NCH*MEM_STRB_W-1:0] ch_strb,
    input  logic [NCH*MEM_DATA_W-1:0] ch_wdata,
    input  logic                      wfi_sleep,
    output logic [NCH*CTR_W-1:0]      stall_ctr,
    output logic [NCH-1:0]            rsp_pending,
    output logic [NCH-1:0]            viol_stall,
    output logic [NCH-1:0]            viol_hold,
    output logic [NCH-1:0]            viol_err,
    output logic                      viol_sleep,
    output logic                      viol_any,
    output logic [7:0]                first_viol
);

    // Reject parameter sets the counters or first_viol encoding cannot represent.
    if (MAX_STALL >= (1 << CTR_W)) begin : g_bad_max_stall
        $error("MAX_STALL must be below 2**CTR_W");
    end
    if (MAX_SLEEP >= (1 << CTR_W)) begin : g_bad_max_sleep
        $error("MAX_SLEEP must be below 2**CTR_W");
    end
    if ((NCH < 1) || (NCH > 64)) begin : g_bad_nch
        $error("NCH must be in 1..64");
    end

    logic [NCH-1:0]   viol_stall_c;
    logic [NCH-1:0]   viol_hold_c;
    logic [NCH-1:0]   viol_err_c;
    logic [CTR_W-1:0] sleep_ctr;
    logic [CTR_W-1:0] sleep_nxt_c;
    logic             sleep_fired;
    logic             viol_sleep_c;
    logic             any_viol_c;
    logic [7:0]       first_code_c;

    // One checker per channel.
    for (genvar i = 0; i < NCH; i++) begin : g_chan
        mem_chan_fairness #(
            .MEM_ADDR_W (MEM_ADDR_W),
            .MEM_DATA_W (MEM_DATA_W),
            .MEM_STRB_W (MEM_STRB_W),
            .PHYS_ADDR_W(PHYS_ADDR_W),
            .ERR_MODE   (ERR_MODE),
            .MAX_STALL  (MAX_STALL),
            .CTR_W      (CTR_W)
        ) u_chan (
            .g_clk       (g_clk),
            .g_resetn    (g_resetn),
            .req         (ch_req[i]),
            .gnt         (ch_gnt[i]),
            .err         (ch_err[i]),
            .addr        (ch_addr[i*MEM_ADDR_W +: MEM_ADDR_W]),
            .wen         (ch_wen[i]),
            .strb        (ch_strb[i*MEM_STRB_W +: MEM_STRB_W]),
            .wdata       (ch_wdata[i*MEM_DATA_W +: MEM_DATA_W]),
            .stall_ctr   (stall_ctr[i*CTR_W +: CTR_W]),
            .rsp_pending (rsp_pending[i]),
            .viol_stall  (viol_stall[i]),
            .viol_hold   (viol_hold[i]),
            .viol_err    (viol_err[i]),
            .viol_stall_c(viol_stall_c[i]),
            .viol_hold_c (viol_hold_c[i]),
            .viol_err_c  (viol_err_c[i])
        );
    end

    // Sleep fires when the count reaches MAX_SLEEP in a sleeping cycle.
    always_comb begin
        sleep_nxt_c  = (sleep_ctr == '1) ? sleep_ctr : sleep_ctr + CTR_W'(1);
        viol_sleep_c = wfi_sleep && (sleep_nxt_c == CTR_W'(MAX_SLEEP)) && !sleep_fired;
    end

    // Saturating sleep counter with once-per-episode report.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            sleep_ctr   <= '0;
            sleep_fired <= 1'b0;
            viol_sleep  <= 1'b0;
        end else begin
            viol_sleep <= viol_sleep_c;
            if (wfi_sleep) begin
                sleep_ctr   <= sleep_nxt_c;
                sleep_fired <= sleep_fired | viol_sleep_c;
            end else begin
                sleep_ctr   <= '0;
                sleep_fired <= 1'b0;
            end
        end
    end

    // Priority encode: lowest class, then lowest channel; later writes win.
    always_comb begin
        any_viol_c   = (|viol_stall_c) | (|viol_hold_c) | (|viol_err_c) | viol_sleep_c;
        first_code_c = '0;
        if (viol_sleep_c) begin
            first_code_c = pack_first_viol(VIOL_SLEEP, 6'd0);
        end
        for (int i = NCH - 1; i >= 0; i--) begin
            if (viol_err_c[i]) first_code_c = pack_first_viol(VIOL_ERR, 6'(i));
        end
        for (int i = NCH - 1; i >= 0; i--) begin
            if (viol_hold_c[i]) first_code_c = pack_first_viol(VIOL_HOLD, 6'(i));
        end
        for (int i = NCH - 1; i >= 0; i--) begin
            if (viol_stall_c[i]) first_code_c = pack_first_viol(VIOL_STALL, 6'(i));
        end
    end

    // Sticky flag and first-violation capture, aligned with the viol_* pulses.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            viol_any   <= 1'b0;
            first_viol <= '0;
        end else begin
            viol_any <= viol_any | any_viol_c;
            if (!viol_any && any_viol_c) begin
                first_viol <= first_code_c;
            end
        end
    end

endmodule

// File: doc/mem_bus_fairness_monitor.md
Name: mem_bus_fairness_monitor

Overview:
Synthesisable, parametrised monitor for NCH request/grant memory channels plus the core WFI sleep signal. It checks bus-protocol fairness (bounded stall, request hold-stability, error-response policy, bounded sleep) and reports violations as registered flags rather than embedded properties. A thin wrapper can turn the flags into formal constraints, or a simulation bench can check them. It sits beside the core in the verification top and is shared by formal and simulation flows.

Parameters:
NCH, 2, number of monitored memory channels (channel 0 = imem, 1 = dmem)
MEM_ADDR_W, 64, request address width
MEM_DATA_W, 64, write data width
MEM_STRB_W, 8, write strobe width
PHYS_ADDR_W, 32, physical address width; any address >= 2^PHYS_ADDR_W is out of range
ERR_MODE, 1, 0 = err must never be set; 1 = err required exactly for out-of-range addresses
MAX_STALL, 5, max consecutive req&&!gnt cycles allowed per channel
MAX_SLEEP, 10, max consecutive wfi_sleep cycles allowed
CTR_W, 5, width of stall and sleep counters (saturating)

Ports:
g_clk  in  1  global clock
g_resetn  in  1  asynchronous active-low reset
ch_req  in  NCH  per-channel request
ch_gnt  in  NCH  per-channel grant (request accepted this cycle)
ch_err  in  NCH  per-channel error; valid in the cycle after req&&gnt
ch_addr  in  NCH*MEM_ADDR_W  request addresses, channel i at [i*MEM_ADDR_W +: MEM_ADDR_W]
ch_wen  in  NCH  write enables
ch_strb  in  NCH*MEM_STRB_W  write strobes
ch_wdata  in  NCH*MEM_DATA_W  write data
wfi_sleep  in  1  core asleep due to WFI
stall_ctr  out  NCH*CTR_W  current consecutive stall count per channel
rsp_pending  out  NCH  response cycle due next cycle (registered req&&gnt)
viol_stall  out  NCH  stall-bound violation pulse
viol_hold  out  NCH  request dropped or changed while stalled
viol_err  out  NCH  error response contradicts ERR_MODE policy
viol_sleep  out  1  sleep-bound violation pulse
viol_any  out  1  sticky OR of all violations since reset
first_viol  out  8  code of the first violation: [7:6] class (0 stall, 1 hold, 2 err, 3 sleep), [5:0] channel index

Behaviour:
- Reset (async, g_resetn=0): all counters, snapshots, rsp_pending, viol_* outputs, viol_any and first_viol go to 0 immediately. Reset mid-transaction discards any pending check. The first cycle after release is treated as idle.
- All viol_* outputs are registered. They pulse one cycle after the offending cycle. Per channel i:
- Stall counter:
  - req&&!gnt: counter increments, saturating at 2^CTR_W-1.
  - req&&gnt or !req: counter clears.
  - viol_stall[i] pulses when the registered counter equals MAX_STALL while req&&!gnt, i.e. in the (MAX_STALL+1)th consecutive stall cycle. It pulses once per stall episode; a re-arm flag is cleared on gnt or !req.
- Hold check:
  - On a req&&!gnt cycle, snapshot addr, wen, strb and wdata, and set the waiting flag.
  - Next cycle while waiting: req must be 1 and addr and wen must match the snapshot. strb and wdata are compared only if the snapshot wen=1.
  - A mismatch pulses viol_hold[i] and clears the waiting flag.
- Error policy:
  - req&&gnt registers rsp_pending[i]=1 and the out-of-range bit (|addr[MEM_ADDR_W-1:PHYS_ADDR_W], 0 if PHYS_ADDR_W>=MEM_ADDR_W).
  - In the rsp_pending cycle, ERR_MODE=0 requires err=0; ERR_MODE=1 requires err == out-of-range bit. A mismatch pulses viol_err[i].
  - A new req&&gnt in the same cycle (back-to-back) re-arms rsp_pending for the next cycle.
  - ch_err outside a rsp_pending cycle is ignored.
- Sleep check:
  - Counter increments while wfi_sleep (saturating) and clears when !wfi_sleep.
  - viol_sleep pulses once when the counter equals MAX_SLEEP while still asleep.
- Sticky flags:
  - viol_any sets on any viol_* pulse and clears only on reset.
  - first_viol latches in the cycle viol_any first sets.
  - Simultaneous violations: lowest class wins, then lowest channel.
- Parameter legality (elaboration error): MAX_STALL and MAX_SLEEP must each be < 2^CTR_W; NCH must be in 1..64.

Decomposition:
- Package mem_fairness_pkg: violation class constants (VIOL_STALL=2'd0, VIOL_HOLD=2'd1, VIOL_ERR=2'd2, VIOL_SLEEP=2'd3), ERR_MODE encodings, and the first_viol packing function.
- Sub-module mem_chan_fairness: one channel's stall counter, snapshot/hold check and error check. It is instantiated NCH times in a generate loop. The top holds the sleep counter and the sticky/priority logic.

Test Plan:
- NCH=2, MAX_STALL=5: hold ch0 req with gnt=0 for 5 cycles, gnt in cycle 6 -> no viol; repeat with 6 stall cycles -> viol_stall[0] pulses once, the cycle after the 6th stall, and first_viol=8'h00.
- Stall ch1 with addr 0x1000, change addr to 0x1008 in the next cycle -> viol_hold[1]=1, first_viol=8'h41. Repeat with wen=0 and wdata changed -> no viol.
- ERR_MODE=1, PHYS_ADDR_W=32: grant addr 0x1_0000_0000 with err=0 next cycle -> viol_err; grant 0x8000_0000 with err=0 -> no viol; back-to-back grants both checked.
- wfi_sleep high for 10 cycles -> viol_sleep pulses at cycle 11 and viol_any=1; high for 9 cycles then low -> no viol.
- Assert g_resetn=0 mid-stall with stall_ctr=3 -> all outputs 0 asynchronously; after release, 5 stall cycles -> no viol.
- Same-cycle stall violation on ch1 and hold violation on ch0 -> first_viol=8'h01 (stall class beats hold).
